// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline slice: stage state encoding,
// control-vector bit positions and data-payload field offsets.
package cpu_pipe_pkg;

    // Occupancy of the EX/MEM elastic stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_t;

    // EX/MEM control vector bit positions.
    localparam int EXMEM_CTRL_W     = 10;
    localparam int CTRL_BRANCH      = 0;
    localparam int CTRL_MEMTOREG    = 1;
    localparam int CTRL_REGWR       = 2;
    localparam int CTRL_MEMWR       = 3;
    localparam int CTRL_JAL         = 4;
    localparam int CTRL_RTYPE_J     = 5;
    localparam int CTRL_RTYPE_L     = 6;
    localparam int CTRL_WRBYTE      = 7;
    localparam int CTRL_LOADBYTE_LO = 8;
    localparam int CTRL_LOADBYTE_HI = 9;

    // EX/MEM data payload field layout; bits above the flags are zero.
    localparam int EXMEM_DATA_W = 110;
    localparam int D_ALU_LSB    = 0;
    localparam int D_ALU_W      = 32;
    localparam int D_BUSB_LSB   = 32;
    localparam int D_BUSB_W     = 32;
    localparam int D_OP_LSB     = 64;
    localparam int D_OP_W       = 6;
    localparam int D_RD_LSB     = 70;
    localparam int D_RD_W       = 5;
    localparam int D_FLAGS_LSB  = 75;
    localparam int D_FLAGS_W    = 3;

    // Packs the EX results into the data payload, zero-filling the padding.
    function automatic logic [EXMEM_DATA_W-1:0] pack_data(
        input logic [D_ALU_W-1:0]   alu,
        input logic [D_BUSB_W-1:0]  busb,
        input logic [D_OP_W-1:0]    op,
        input logic [D_RD_W-1:0]    rd,
        input logic [D_FLAGS_W-1:0] flags
    );
        logic [EXMEM_DATA_W-1:0] d;
        d = '0;
        d[D_ALU_LSB   +: D_ALU_W]   = alu;
        d[D_BUSB_LSB  +: D_BUSB_W]  = busb;
        d[D_OP_LSB    +: D_OP_W]    = op;
        d[D_RD_LSB    +: D_RD_W]    = rd;
        d[D_FLAGS_LSB +: D_FLAGS_W] = flags;
        return d;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
// Ports: clk, rst_n, i_inc (count enable), o_cnt (current count, sticks at all-ones).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// Elastic EX->MEM stage: valid/ready handshake with a main and a skid entry,
// synchronous flush of in-flight control, and a saturating stall counter.
// Ports: clk, rst_n, flush; in_valid/in_ready/in_data/in_ctrl from EX;
// out_valid/out_ready/out_data/out_ctrl to MEM; stall_cnt for perf debug.
module ex_mem_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 110,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       r_state;
    logic              r_in_ready;
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    pipe_state_t       w_state_nxt;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_stall;

    // in_ready is a flop, so FULL never accepts and EX sees no
    // combinational path from out_ready.
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_main_valid & out_ready;
    assign w_stall    = r_main_valid & ~out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_main_ctrl_nxt  = r_main_ctrl;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_ctrl_nxt  = r_skid_ctrl;

        if (flush) begin
            // Kill everything, including a beat accepted this cycle;
            // clearing ctrl guarantees no stale write enables survive.
            w_state_nxt      = ST_EMPTY;
            w_main_valid_nxt = 1'b0;
            w_main_ctrl_nxt  = '0;
            w_skid_valid_nxt = 1'b0;
            w_skid_ctrl_nxt  = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt      = ST_BUSY;
                        w_main_valid_nxt = 1'b1;
                        w_main_data_nxt  = in_data;
                        w_main_ctrl_nxt  = in_ctrl;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_data_nxt = in_data;
                        w_main_ctrl_nxt = in_ctrl;
                    end else if (w_in_fire) begin
                        w_state_nxt      = ST_FULL;
                        w_skid_valid_nxt = 1'b1;
                        w_skid_data_nxt  = in_data;
                        w_skid_ctrl_nxt  = in_ctrl;
                    end else if (w_out_fire) begin
                        w_state_nxt      = ST_EMPTY;
                        w_main_valid_nxt = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ST_BUSY;
                        w_main_data_nxt  = r_skid_data;
                        w_main_ctrl_nxt  = r_skid_ctrl;
                        w_skid_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt      = ST_EMPTY;
                    w_main_valid_nxt = 1'b0;
                    w_skid_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_in_ready   <= 1'b1;
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_in_ready   <= (w_state_nxt != ST_FULL);
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_main_ctrl  <= w_main_ctrl_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stall),
        .o_cnt (stall_cnt)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: directed scenarios plus random traffic
// against a queue-based occupancy model; a CNT_W=4 copy checks saturation.
module tb_ex_mem_pipe_reg;
    import cpu_pipe_pkg::*;

    localparam int DW = 110;
    localparam int CW = 10;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   stall_cnt;

    logic          in_ready4;
    logic          out_valid4;
    logic [DW-1:0] out_data4;
    logic [CW-1:0] out_ctrl4;
    logic [3:0]    stall_cnt4;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    int    m_stall = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    ex_mem_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_ctrl(out_ctrl4),
        .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_d();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic logic [CW-1:0] rnd_c();
        logic [31:0] t;
        t = $urandom();
        return t[CW-1:0];
    endfunction

    // Monitor: compare DUT against the occupancy model, then advance the
    // model by the events the coming edge will apply.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_stall = 0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_ctrl", out_ctrl, 0);
            chk("rst_stall_cnt", stall_cnt, 0);
            chk("rst_stall_cnt4", stall_cnt4, 0);
        end else begin
            bit ready_now;
            bit has;
            has = exp_q.size() > 0;
            ready_now = exp_q.size() < 2;
            chk("in_ready", in_ready, ready_now);
            chk("out_valid", out_valid, has);
            if (has) begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_ctrl", out_ctrl, exp_q[0].c);
            end else begin
                chk("out_ctrl_idle", out_ctrl, 0);
            end
            chk("stall_cnt", stall_cnt, m_stall);
            chk("stall_cnt4", stall_cnt4, (m_stall > 15) ? 15 : m_stall);
            if (has && !out_ready && m_stall < 65535) m_stall++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (has && out_ready) void'(exp_q.pop_front());
                if (in_valid && ready_now) exp_q.push_back('{d: in_data, c: in_ctrl});
            end
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, rnd_d(), rnd_c(), 1, 0);
    endtask

    task automatic single_beat();
        step(1, pack_data(32'h1234, 32'h0, 6'h0, 5'h0, 3'h0), 10'h024, 1, 0);
        idle(3);
    endtask

    initial begin
        logic [DW-1:0] a, b, c;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        single_beat();

        a = pack_data(32'hAAAA_0001, 32'h1111_1111, 6'h23, 5'd3, 3'b001);
        b = pack_data(32'hBBBB_0002, 32'h2222_2222, 6'h2B, 5'd7, 3'b010);
        c = pack_data(32'hCCCC_0003, 32'h3333_3333, 6'h00, 5'd9, 3'b100);
        step(1, a, 10'h006, 0, 0);
        step(1, b, 10'h00A, 0, 0);
        step(1, c, 10'h3FF, 0, 0);
        step(1, c, 10'h3FF, 0, 0);
        step(1, c, 10'h3FF, 1, 0);
        idle(4);

        step(1, a, 10'h3FF, 0, 0);
        step(1, b, 10'h3FF, 0, 0);
        step(1, c, 10'h3FF, 0, 1);
        idle(2);
        step(1, a, 10'h3FF, 0, 0);
        step(1, b, 10'h155, 1, 1);
        idle(2);

        for (int i = 0; i < 20; i++) step(1, rnd_d(), rnd_c(), 1, 0);
        idle(2);

        for (int i = 0; i < 1500; i++)
            step(($urandom() % 4) != 0, rnd_d(), rnd_c(),
                 $urandom() % 2, ($urandom() % 24) == 0);
        idle(3);

        step(1, rnd_d(), rnd_c(), 0, 0);
        for (int i = 0; i < 20; i++) step(0, rnd_d(), rnd_c(), 0, 0);
        idle(2);

        step(1, a, 10'h3FF, 0, 0);
        step(1, b, 10'h2AA, 0, 0);
        step(1, c, 10'h155, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", in_ready, 1);
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        chk("async_out_ctrl", out_ctrl, 0);
        chk("async_stall_cnt", stall_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        single_beat();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
